// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and decode helpers for the load/store unit
//
// Contents:
//   DEFAULT_MEM_DEPTH  default number of 32-bit words in the data memory
//   F3_*               RV32I load/store funct3 codes
//   ST_* / lsu_state_t FSM state encoding
//   f3_illegal()       funct3 legality for loads and stores
//   misaligned()       natural-alignment check for half and word accesses

package lsu_pkg;

  localparam int DEFAULT_MEM_DEPTH = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LD_REQ  = 3'd1;
  localparam logic [2:0] ST_LD_DATA = 3'd2;
  localparam logic [2:0] ST_RMW_RD  = 3'd3;
  localparam logic [2:0] ST_RMW_WR  = 3'd4;
  localparam logic [2:0] ST_ST_WR   = 3'd5;
  localparam logic [2:0] ST_ERR     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_LD_REQ  = ST_LD_REQ,
    S_LD_DATA = ST_LD_DATA,
    S_RMW_RD  = ST_RMW_RD,
    S_RMW_WR  = ST_RMW_WR,
    S_ST_WR   = ST_ST_WR,
    S_ERR     = ST_ERR
  } lsu_state_t;

  // Stores only have byte/half/word; loads add the two unsigned variants.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic legal;
    if (we) begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
    end
    return !legal;
  endfunction

  // funct3[1:0] carries the access size for every legal code.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane extraction and store-merge for a word-wide memory
//
// Ports:
//   word        in  32  word read back from memory
//   funct3      in  3   access type (size in [1:0], unsigned flag in [2])
//   byte_off    in  2   byte offset within the word
//   store_data  in  32  store data from the core (low byte/half for sub-word)
//   load_data   out 32  selected lane, sign- or zero-extended
//   store_word  out 32  word with the addressed lane replaced by store data

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = word;
    endcase

    // Lanes not addressed keep the value just read back.
    store_word = word;
    case (funct3[1:0])
      2'b00: store_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
      2'b01: begin
        if (byte_off[1]) begin
          store_word[31:16] = store_data[15:0];
        end else begin
          store_word[15:0] = store_data[15:0];
        end
      end
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store sequencer for a word-addressed single-port data memory
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req_*         request from execute: valid/ready handshake, we, funct3, byte addr, store data
//   resp_*        one-cycle response pulse with extended load data and fault flag
//   mem_read      memory read strobe (data returns the following cycle on mem_rdata)
//   mem_write     memory write strobe
//   mem_addr      word index of the latched request, 0 while idle
//   mem_wdata     write data (full store word or merged sub-word)
//   mem_rdata     registered read data from memory

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(MEM_DEPTH);

  lsu_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;

  logic        accept;
  logic        req_fault;
  logic        mem_read_c, mem_write_c;
  logic [31:0] mem_wdata_c;
  logic        resp_set;
  logic        resp_err_d;
  logic [31:0] resp_rdata_d;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready = (state_q == S_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  assign req_fault = f3_illegal(req_we, req_funct3) |
                     misaligned(req_funct3, req_addr[1:0]) |
                     (req_addr[ADDR_W-1:2] >= DEPTH_IDX);

  lsu_lane_align u_lane_align (
    .word       (mem_rdata),
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .store_data (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_wdata_c  = 32'b0;
    resp_set     = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_fault) begin
            state_d = S_ERR;
          end else if (!req_we) begin
            state_d = S_LD_REQ;
          end else if (req_funct3 == F3_W) begin
            state_d = S_ST_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LD_REQ: begin
        mem_read_c = 1'b1;
        state_d    = S_LD_DATA;
      end
      S_LD_DATA: begin
        resp_set     = 1'b1;
        resp_rdata_d = load_data;
        state_d      = S_IDLE;
      end
      S_RMW_RD: begin
        mem_read_c = 1'b1;
        state_d    = S_RMW_WR;
      end
      S_RMW_WR: begin
        // mem_rdata here is the word fetched in RMW_RD.
        mem_write_c = 1'b1;
        mem_wdata_c = store_word;
        resp_set    = 1'b1;
        state_d     = S_IDLE;
      end
      S_ST_WR: begin
        mem_write_c = 1'b1;
        mem_wdata_c = wdata_q;
        resp_set    = 1'b1;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        resp_set   = 1'b1;
        resp_err_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are gated by rst so an interrupted RMW never lands a partial write.
  assign mem_read  = mem_read_c & ~rst;
  assign mem_write = mem_write_c & ~rst;
  assign mem_wdata = rst ? 32'b0 : mem_wdata_c;
  assign mem_addr  = (state_q != S_IDLE) ? {2'b00, addr_q[ADDR_W-1:2]} : '0;

  // Response is registered, so it appears in the cycle the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      funct3_q   <= 3'b0;
      wdata_q    <= 32'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
      end
      resp_valid <= resp_set;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'b0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Data memory: 64 words, registered read, backdoor preload port.
  logic [31:0] mem_arr [64];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'b0;

  always @(posedge clk) begin
    if (pre_en) mem_arr[pre_idx] <= pre_val;
    else if (mem_write) mem_arr[mem_addr[5:0]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem_arr[mem_addr[5:0]];
  end

  // Reference model: byte-addressed memory plus an in-order queue of accepted requests.
  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          fault;
    int          due;
  } req_t;

  logic [7:0]  ref_bytes [256];
  req_t        q[$];
  int          cyc = 0;
  logic [31:0] last_rdata = 32'b0;
  logic        last_err = 1'b0;
  int          resp_cnt = 0;
  int          overlap_cnt = 0;
  int          wr_cycles = 0;
  int          rd_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit ref_fault(bit we, logic [2:0] f3, logic [31:0] a);
    int size;
    if (we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
      return 1'b1;
    size = 1 << f3[1:0];
    if ((a % size) != 0) return 1'b1;
    if ((a >> 2) >= 64) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin : monitor
    req_t        r;
    logic [31:0] v;
    int          size;
    int          base;
    if (pre_en) begin
      for (int i = 0; i < 4; i++) ref_bytes[int'(pre_idx) * 4 + i] = pre_val[8*i +: 8];
    end
    if (rst) begin
      q.delete();
      chk("rst_no_read", {31'b0, mem_read}, 32'd0);
      chk("rst_no_write", {31'b0, mem_write}, 32'd0);
    end else begin
      chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      if (mem_write) wr_cycles++;
      if (mem_read) rd_cycles++;
      if (mem_read || mem_write) begin
        if (q.size() == 0) chk("access_without_request", q.size(), 32'd1);
        else begin
          chk("access_on_fault", {31'b0, q[0].fault}, 32'd0);
          chk("mem_addr", mem_addr, q[0].addr >> 2);
        end
      end
      if (resp_valid) begin
        resp_cnt++;
        if (q.size() == 0) chk("resp_without_request", q.size(), 32'd1);
        else begin
          r = q.pop_front();
          chk("resp_latency", cyc, r.due);
          v = 32'b0;
          if (!r.fault) begin
            size = 1 << r.f3[1:0];
            base = int'(r.addr[7:0]);
            if (r.we) begin
              for (int i = 0; i < size; i++) ref_bytes[base + i] = r.wdata[8*i +: 8];
            end else begin
              for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
              if (size < 4 && !r.f3[2] && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            end
          end
          chk("resp_err", {31'b0, resp_err}, {31'b0, r.fault});
          chk("resp_rdata", resp_rdata, v);
          last_rdata = resp_rdata;
          last_err   = resp_err;
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        chk("resp_missing", {31'b0, resp_valid}, 32'd1);
        r = q.pop_front();
      end
      if (req_valid && req_ready) begin
        if (resp_valid) overlap_cnt++;
        r.we    = req_we;
        r.f3    = req_funct3;
        r.addr  = req_addr;
        r.wdata = req_wdata;
        r.fault = ref_fault(req_we, req_funct3, req_addr);
        r.due   = cyc + ((r.fault || (req_we && req_funct3 == 3'b010)) ? 2 : 3);
        q.push_back(r);
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    pre_en  = 1'b1;
    pre_idx = 6'(idx);
    pre_val = val;
    @(posedge clk); #1;
    pre_en  = 1'b0;
  endtask

  // Leaves req_valid high; returns 1 time unit after the accept edge.
  task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bit got;
    got        = 1'b0;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("drain", q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic req_one(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    send(we, f3, a, d);
    req_valid = 1'b0;
    wait_done();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
    chk({tag, "_mem_read"}, {31'b0, mem_read}, 32'd0);
    chk({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          w0, r0, rc0, ov0;
    bit          rw;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_word;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'b0;
    req_wdata  = 32'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Word store then load back.
    w0 = wr_cycles;
    req_one(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF);
    chk("sw_write_cycles", wr_cycles - w0, 32'd1);
    chk("sw_mem_word", mem_arr[2], 32'hDEAD_BEEF);
    req_one(1'b0, 3'b010, 32'h08, 32'h0);
    chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);

    // Byte store by read-modify-write, then byte loads.
    preload(2, 32'h1122_3344);
    r0 = rd_cycles;
    w0 = wr_cycles;
    req_one(1'b1, 3'b000, 32'h09, 32'h0000_00AA);
    chk("sb_read_cycles", rd_cycles - r0, 32'd1);
    chk("sb_write_cycles", wr_cycles - w0, 32'd1);
    chk("sb_mem_word", mem_arr[2], 32'h1122_AA44);
    req_one(1'b0, 3'b100, 32'h09, 32'h0);
    chk("lbu_rdata", last_rdata, 32'h0000_00AA);
    req_one(1'b0, 3'b000, 32'h09, 32'h0);
    chk("lb_rdata", last_rdata, 32'hFFFF_FFAA);

    // Half store in the upper lane, then half loads.
    preload(2, 32'h1122_3344);
    req_one(1'b1, 3'b001, 32'h0A, 32'h0000_8001);
    chk("sh_mem_word", mem_arr[2], 32'h8001_3344);
    req_one(1'b0, 3'b001, 32'h0A, 32'h0);
    chk("lh_rdata", last_rdata, 32'hFFFF_8001);
    req_one(1'b0, 3'b101, 32'h0A, 32'h0);
    chk("lhu_rdata", last_rdata, 32'h0000_8001);

    // Faults: no memory traffic, error response two cycles after accept.
    r0 = rd_cycles;
    w0 = wr_cycles;
    req_one(1'b0, 3'b010, 32'h06, 32'h0);
    chk("fault_lw_misaligned_err", {31'b0, last_err}, 32'd1);
    req_one(1'b1, 3'b001, 32'h03, 32'h1234);
    chk("fault_sh_misaligned_err", {31'b0, last_err}, 32'd1);
    req_one(1'b0, 3'b010, 32'h100, 32'h0);
    chk("fault_range_err", {31'b0, last_err}, 32'd1);
    req_one(1'b0, 3'b011, 32'h00, 32'h0);
    chk("fault_funct3_err", {31'b0, last_err}, 32'd1);
    chk("fault_funct3_rdata", last_rdata, 32'd0);
    chk("fault_no_mem_access", (rd_cycles - r0) + (wr_cycles - w0), 32'd0);

    // Back-to-back: req_valid never drops.
    ov0 = overlap_cnt;
    rc0 = resp_cnt;
    for (int k = 0; k < 8; k++) begin
      a = 32'h10 + 32'(4 * (k / 2));
      if (k % 2 == 0) send(1'b1, 3'b010, a, $urandom);
      else            send(1'b0, 3'b010, a, 32'h0);
    end
    req_valid = 1'b0;
    wait_done();
    chk("b2b_overlap", ov0 >= 0 ? overlap_cnt - ov0 : 0, 32'd7);
    chk("b2b_resp_count", resp_cnt - rc0, 32'd8);

    // Reset while the SB is reading.
    preload(8, 32'hCAFE_F00D);
    rc0 = resp_cnt;
    send(1'b1, 3'b000, 32'h21, 32'h55);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_req_ready", {31'b0, req_ready}, 32'd1);
    check_idle_outputs("rst_rd");
    chk("rst_rd_mem_word", mem_arr[8], 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Reset while the SH write strobe would be active.
    send(1'b1, 3'b001, 32'h22, 32'hBEEF);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_req_ready", {31'b0, req_ready}, 32'd1);
    check_idle_outputs("rst_wr");
    chk("rst_wr_mem_word", mem_arr[8], 32'hCAFE_F00D);
    chk("rst_no_response", resp_cnt - rc0, 32'd0);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7) begin
        if (rw) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = $urandom_range(256, 4095);
        default: a = $urandom_range(0, 255);
      endcase
      d = $urandom;
      send(rw, f3, a, d);
      if ($urandom_range(0, 2) != 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
    req_valid = 1'b0;
    wait_done();

    for (int i = 0; i < 64; i++) begin
      exp_word = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
      chk($sformatf("final_mem_%0d", i), mem_arr[i], exp_word);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the single-port data memory (MEM). Accepts RV32I load/store requests from the execute stage and sequences the memory's MemRead/MemWrite controls.
- The memory is word-addressed with no byte enables and has a 1-cycle registered read. This block therefore performs byte/half extraction with sign/zero extension, and read-modify-write for SB/SH.
- Stalls the core via req_ready and returns one response per accepted request.

Parameters:
MEM_DEPTH, 64, number of 32-bit words in the data memory; word index >= MEM_DEPTH is an access fault
ADDR_W, 32, width of the byte address from the core

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept; = (state==IDLE) & ~rst
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for SB/SH)
resp_valid  out  1  one-cycle pulse, response for the oldest accepted request
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_err  out  1  misaligned, illegal funct3 or out-of-range address
mem_read  out  1  to MEM MemRead
mem_write  out  1  to MEM MemWrite
mem_addr  out  32  word index = req_addr[31:2], zero-extended
mem_wdata  out  32  to MEM write_data
mem_rdata  in  32  from MEM read_data (valid the cycle after mem_read)

Behaviour:
- Handshake: a request is accepted on an edge where req_valid & req_ready. The block latches addr, we, funct3 and wdata. Inputs are ignored while not ready.
- FSM states: IDLE, LD_REQ, LD_DATA, RMW_RD, RMW_WR, ST_WR, ERR.
- Decoding on accept:
  - Fault → ERR. Faults are: misaligned (LH/LHU/SH addr[0]≠0; LW/SW addr[1:0]≠0), illegal funct3 (loads 011/110/111, stores ≥011), or addr[31:2] ≥ MEM_DEPTH.
  - Load → LD_REQ.
  - SW → ST_WR.
  - SB/SH → RMW_RD.
- LD_REQ: mem_read=1. → LD_DATA.
- LD_DATA: mem_read=0. Select lane by addr[1:0] from mem_rdata. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Register into resp_rdata, pulse resp_valid. → IDLE.
- RMW_RD: mem_read=1. → RMW_WR.
- RMW_WR: mem_write=1. mem_wdata = mem_rdata with the addressed byte/half replaced by req_wdata[7:0]/[15:0]; other lanes are preserved. Pulse resp_valid with rdata=0. → IDLE.
- ST_WR: mem_write=1, mem_wdata=req_wdata. Pulse resp_valid. → IDLE.
- ERR: no memory access. Pulse resp_valid with resp_err=1 and rdata=0. → IDLE.
- mem_read and mem_write are never both 1 in the same cycle. Both are 0 in IDLE and ERR.
- mem_addr holds the latched word index in every non-IDLE state and is 0 in IDLE.
- Latency from the accept edge to resp_valid high:
  - word store and fault: 2nd cycle
  - load and sub-word store: 3rd cycle
- resp_valid lasts exactly one cycle and coincides with IDLE, so a new request may be accepted in that same cycle (back-to-back throughput).
- Reset values: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; req_ready=0 while rst=1.
- Reset mid-operation:
  - The in-flight request is dropped with no response.
  - mem_read and mem_write are gated by ~rst combinationally, so no write reaches memory in the rst cycle.
- Address bits [1:0] are never forwarded to memory. Bits above the word index only matter for the range check.
- All responses return in request order. At most one request is outstanding.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - state encoding localparams
  - default MEM_DEPTH
- One combinational sub-module lsu_lane_align:
  - inputs: word, funct3, addr[1:0], store data
  - outputs: extended load value and merged store word
  - Used by LD_DATA and RMW_WR.

Test Plan:
- SW addr=0x08 data=0xDEADBEEF, then LW addr=0x08 → mem_write for 1 cycle at mem_addr=2; load resp_rdata=0xDEADBEEF with resp_valid on the 3rd cycle after accept.
- Word 2 preloaded 0x11223344; SB addr=0x09 data=0xAA → RMW read, then write 0x1122AA44; LBU 0x09 → 0x000000AA; LB 0x09 → 0xFFFFFFAA.
- SH addr=0x0A data=0x8001 over 0x11223344 → word 0x80013344; LH 0x0A → 0xFFFF8001; LHU 0x0A → 0x00008001.
- LW addr=0x06, SH addr=0x03, LW addr=0x100 (index 64), funct3=011 → each gives resp_err=1, rdata=0 on the 2nd cycle; mem_read and mem_write stay 0 throughout.
- req_valid held high with alternating SW/LW to 4 addresses → each new accept coincides with the previous resp_valid; responses in order; never mem_read & mem_write together.
- rst asserted during RMW_RD of an SB → no mem_write, no resp_valid; after release, the memory word is unchanged, req_ready=1 and outputs are at reset values.
